// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream in, instruction-memory write port out
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader with XOR checksum gate on cpu_run
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_start,
    prog_loader_if.slave  bus,
    output logic          cpu_run,
    output logic          busy,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CHK, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              start_ok;
    logic [7:0]        count;
    logic [7:0]        csum;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] waddr;

    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        cpu_run      = (state == DONE);
        err          = (state == ERR);
        start_ok     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                start_ok = load_start;
                if (load_start) state_nxt = HDR;
            end
            HDR, HI, LO, CHK: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        accept = bus.in_valid && bus.in_ready;
        if (accept) begin
            case (state)
                HDR:     state_nxt = HI;
                HI:      state_nxt = LO;
                // count holds words still to write including this one; N=0 wraps to 256
                LO:      state_nxt = (count == 8'd1) ? CHK : HI;
                CHK:     state_nxt = (bus.in_data == csum) ? DONE : ERR;
                default: state_nxt = state;
            endcase
        end
    end

    // imem_addr/imem_wdata only change together with the write strobe
    always_ff @(posedge clk) begin
        if (rstn) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            count          <= 8'd0;
            csum           <= 8'd0;
            hi_byte        <= 8'd0;
            waddr          <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (start_ok) begin
                waddr <= '0;
                csum  <= 8'd0;
            end
            if (accept) begin
                case (state)
                    HDR: count <= bus.in_data;
                    HI: begin
                        hi_byte <= bus.in_data;
                        csum    <= csum ^ bus.in_data;
                    end
                    LO: begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= waddr;
                        bus.imem_wdata <= DATA_W'({hi_byte, bus.in_data});
                        waddr          <= waddr + 1'b1;
                        count          <= count - 8'd1;
                        csum           <= csum ^ bus.in_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width (256 words).
REQ-002 Parameter DATA_W, default 16, instruction word width; fixed at 2 bytes per word.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-high (asserted = 1) despite the name.
REQ-005 load_start  input  1  single-cycle pulse that begins a program load.
REQ-006 in_valid  input  1  byte-stream valid from the host link.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  instruction memory write address.
REQ-011 imem_wdata  output  DATA_W  instruction memory write data.
REQ-012 cpu_run  output  1  releases the processor; high only after a verified load.
REQ-013 busy  output  1  load in progress.
REQ-014 err  output  1  last load failed its checksum.

Function
REQ-015 Byte accepted only on a cycle with in_valid=1 and in_ready=1; in_valid without in_ready has no effect and the byte is not consumed.
REQ-016 States: IDLE, HDR, HI, LO, CHK, DONE, ERR; busy=1 in HDR/HI/LO/CHK only.
REQ-017 in_ready=1 in HDR, HI, LO, CHK; 0 in IDLE, DONE, ERR.
REQ-018 IDLE/DONE/ERR + load_start -> HDR next cycle; clears cpu_run, err, word address (0) and checksum (0x00).
REQ-019 HDR: accepted byte = word count N; N=0 means 256 words; -> HI.
REQ-020 HI: accepted byte latched as imem_wdata[15:8]; -> LO.
REQ-021 LO: accepted byte latched as imem_wdata[7:0]; imem_we=1 for exactly the following cycle with current word address.
REQ-022 After each write, address increments by 1 modulo 2^ADDR_W; remaining count decrements; count reaching 0 -> CHK, otherwise -> HI.
REQ-023 Running checksum = XOR of every payload byte (HI and LO bytes), header excluded.
REQ-024 CHK: accepted byte compared to running checksum; equal -> DONE, unequal -> ERR.
REQ-025 DONE: cpu_run=1 continuously until reset or next load_start.
REQ-026 ERR: err=1, cpu_run=0 until reset or next load_start.
REQ-027 load_start while busy is ignored; the load in progress continues.
REQ-028 imem_addr and imem_wdata hold their last values when imem_we=0.
REQ-029 No byte consumed during the imem_we cycle is lost: in_ready may stay high; a byte accepted in that cycle is processed normally.
REQ-030 Latency: last checksum byte accepted at cycle t -> cpu_run or err high at t+1.

Reset
REQ-031 rstn=1 at a clock edge -> IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, busy=0, err=0, checksum=0, count=0.
REQ-032 Reset mid-load aborts immediately; no further imem_we; partially written words are not undone.

Verification
REQ-033 load_start; bytes 02,12,34,AB,CD,8E -> writes addr0=0x1234, addr1=0xABCD; checksum 0x12^0x34^0xAB^0xCD=0x40 != 0x8E -> err=1, cpu_run=0.
REQ-034 Same stream with checksum byte 40 -> two writes as above, cpu_run=1 one cycle after checksum byte, busy=0.
REQ-035 Header 00 followed by 512 payload bytes -> 256 writes, addr 0..255, final address wraps to 0; correct checksum -> cpu_run=1.
REQ-036 in_valid toggled randomly mid-load, plus load_start pulsed while busy -> identical memory image and result to back-to-back stream; load not restarted.
REQ-037 rstn asserted after HI byte of word 1 -> next cycle IDLE, all outputs at reset values, no imem_we for word 1.
REQ-038 From DONE, load_start -> cpu_run drops next cycle, busy=1, address restarts at 0.
